// File: rtl/maxpool_relu_unit.sv
// maxpool_relu_unit: reads the conv buffer per kernel, applies signed max pooling
// plus ReLU, and writes one pooled value per window into the pool buffer.
module maxpool_relu_unit #(
   parameter int DATA_WIDTH    = 16,
   parameter int CONV_LEN      = 25,
   parameter int KERNELS       = 4,
   parameter int POOL_SIZE     = 2,
   parameter int POOL_STRIDE   = 2,
   parameter int IN_ADDR_BITS  = 7,
   parameter int OUT_ADDR_BITS = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [IN_ADDR_BITS-1:0]  rd_address,
   input  logic [DATA_WIDTH-1:0]    rd_data,
   output logic [OUT_ADDR_BITS-1:0] wr_address,
   output logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     write
);
   localparam int POOLED_LEN = (CONV_LEN - POOL_SIZE) / POOL_STRIDE + 1;
   localparam int CW = IN_ADDR_BITS;
   typedef enum logic [2:0] {IDLE, FETCH, LAST, WRITE, DONE} state_t;
   state_t state;
   logic [CW-1:0] k, w, j, nk, nw;
   logic [DATA_WIDTH-1:0] mx, cand;
   logic first, last_win;
   function automatic logic [CW-1:0] rd_addr(input logic [CW-1:0] kk, ww, jj);
      return CW'(kk * CW'(CONV_LEN) + ww * CW'(POOL_STRIDE) + jj);
   endfunction
   // rd_data lags the address by one cycle, so the first sample of a window lands
   // on the second FETCH cycle (or in LAST when a window holds a single element)
   always_comb begin
      first    = (state == FETCH && j == CW'(1)) || (state == LAST && POOL_SIZE == 1);
      cand     = (first || $signed(rd_data) > $signed(mx)) ? rd_data : mx;
      last_win = k == CW'(KERNELS - 1) && w == CW'(POOLED_LEN - 1);
      nk       = (w == CW'(POOLED_LEN - 1)) ? k + 1'b1 : k;
      nw       = (w == CW'(POOLED_LEN - 1)) ? '0 : w + 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         write      <= 1'b0;
         rd_address <= '0;
         wr_address <= '0;
         wr_data    <= '0;
         k          <= '0;
         w          <= '0;
         j          <= '0;
         mx         <= '0;
      end else begin
         done  <= 1'b0;
         write <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state      <= FETCH;
               busy       <= 1'b1;
               k          <= '0;
               w          <= '0;
               j          <= '0;
               rd_address <= '0;
            end
            FETCH: begin
               if (j != '0) mx <= cand;
               if (j == CW'(POOL_SIZE - 1)) state <= LAST;
               else begin
                  j          <= j + 1'b1;
                  rd_address <= rd_addr(k, w, j + 1'b1);
               end
            end
            LAST: begin
               mx         <= cand;
               state      <= WRITE;
               write      <= 1'b1;
               wr_address <= OUT_ADDR_BITS'(k * CW'(POOLED_LEN) + w);
               wr_data    <= cand[DATA_WIDTH-1] ? '0 : cand;
            end
            WRITE: if (last_win) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else begin
               state      <= FETCH;
               k          <= nk;
               w          <= nw;
               j          <= '0;
               rd_address <= rd_addr(nk, nw, '0);
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
